stim_gen: RTL and testbench

Operand stimulus generator for the arithmetic testbench. It sits directly upstream of the DUT and the monitor, and drives the operand pair consumed by both. It emits a programmed number of operand vectors, one per clk, in one of four patterns, then reports completion. Run control uses a start/done handshake with a hold input for throttling.

---
 rtl/stim_gen_if.sv | 28 ++
 rtl/stim_gen.sv | 218 +++++++++++++++++++++
 tb/tb_stim_gen.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stim_gen_if.sv
// Operand stimulus bus: run control in, operand pair and status out.
// master = controller side, slave = stim_gen.
interface stim_gen_if #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
);
    logic             i_start;
    logic [1:0]       i_mode;
    logic [LEN_W-1:0] i_len;
    logic             i_hold;
    logic [WIDTH-1:0] o_ia;
    logic [WIDTH-1:0] o_ib;
    logic             o_valid;
    logic             o_busy;
    logic             o_done;
    logic [LEN_W-1:0] o_count;
    logic [WIDTH-1:0] o_sig;

    modport master (
        output i_start, i_mode, i_len, i_hold,
        input  o_ia, o_ib, o_valid, o_busy, o_done, o_count, o_sig
    );

    modport slave (
        input  i_start, i_mode, i_len, i_hold,
        output o_ia, o_ib, o_valid, o_busy, o_done, o_count, o_sig
    );
endinterface

// File: rtl/stim_gen.sv
// Operand stimulus generator: random / walking-ones / corner / exhaustive vectors.
// Optional running signature on o_sig when STIM_GEN_SIG_EN is defined.
module stim_gen #(
    parameter int          WIDTH  = 32,
    parameter int          LEN_W  = 16,
    parameter logic [31:0] SEED_A = 32'h0000_0001,
    parameter logic [31:0] SEED_B = 32'h0000_ACE1
) (
    input  logic     clk,
    input  logic     reset,
    stim_gen_if.slave bus
);
    localparam int               K_W         = $clog2(WIDTH);
    localparam logic [31:0]      SEED_A_INIT = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
    localparam logic [31:0]      SEED_B_INIT = (SEED_B == 32'd0) ? 32'd1 : SEED_B;
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MSB         = ONE << (WIDTH - 1);
    localparam logic [WIDTH-1:0] SMAX        = MSB - ONE;
    localparam logic [K_W-1:0]   K_LAST      = K_W'(WIDTH - 1);
    localparam logic [LEN_W-1:0] CNT_MAX     = {LEN_W{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       mode_reg, mode_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] ia_reg, ia_next, ib_reg, ib_next;
    logic             valid_reg, valid_next;
    logic [31:0]      xa_reg, xa_next, xb_reg, xb_next;
    logic [K_W-1:0]   k_reg, k_next;
    logic [2:0]       ci_reg, ci_next;
    logic [WIDTH-1:0] ea_reg, ea_next, eb_reg, eb_next;

    logic             accept, gen;
    logic [1:0]       mode_cur;
    logic [K_W-1:0]   k_cur;
    logic [2:0]       ci_cur;
    logic [WIDTH-1:0] ea_cur, eb_cur;
    logic [31:0]      xa_step, xb_step;
    logic [WIDTH-1:0] vec_a, vec_b;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] s;
        s = x ^ (x << 13);
        s = s ^ (s >> 17);
        s = s ^ (s << 5);
        return s;
    endfunction

    // Pattern generator: on an accepted start the deterministic pattern
    // indices restart from zero in the same cycle that emits the first vector.
    always_comb begin
        accept   = (state_reg != RUN) && bus.i_start;
        gen      = accept ? (bus.i_len != '0)
                          : ((state_reg == RUN) && !bus.i_hold && (count_reg != len_reg));
        mode_cur = accept ? bus.i_mode : mode_reg;
        k_cur    = accept ? '0 : k_reg;
        ci_cur   = accept ? '0 : ci_reg;
        ea_cur   = accept ? '0 : ea_reg;
        eb_cur   = accept ? '0 : eb_reg;
        xa_step  = xorshift32(xa_reg);
        xb_step  = xorshift32(xb_reg);
        vec_a    = '0;
        vec_b    = '0;
        xa_next  = xa_reg;
        xb_next  = xb_reg;
        k_next   = k_cur;
        ci_next  = ci_cur;
        ea_next  = ea_cur;
        eb_next  = eb_cur;
        case (mode_cur)
            2'd0: begin
                vec_a = xa_step[WIDTH-1:0];
                vec_b = xb_step[WIDTH-1:0];
            end
            2'd1: begin
                vec_a = ONE << k_cur;
                vec_b = ~(ONE << k_cur);
            end
            2'd2: begin
                case (ci_cur)
                    3'd0: begin vec_a = '0;       vec_b = '0;       end
                    3'd1: begin vec_a = '0;       vec_b = ALL_ONES; end
                    3'd2: begin vec_a = ALL_ONES; vec_b = '0;       end
                    3'd3: begin vec_a = ALL_ONES; vec_b = ALL_ONES; end
                    3'd4: begin vec_a = ONE;      vec_b = ALL_ONES; end
                    3'd5: begin vec_a = ALL_ONES; vec_b = ONE;      end
                    3'd6: begin vec_a = MSB;      vec_b = MSB;      end
                    default: begin vec_a = SMAX;  vec_b = ONE;      end
                endcase
            end
            default: begin
                vec_a = ea_cur;
                vec_b = eb_cur;
            end
        endcase
        if (gen) begin
            case (mode_cur)
                2'd0: begin
                    xa_next = xa_step;
                    xb_next = xb_step;
                end
                2'd1: k_next = (k_cur == K_LAST) ? '0 : k_cur + K_W'(1);
                2'd2: ci_next = ci_cur + 3'd1;
                default: begin
                    ea_next = ea_cur + ONE;
                    if (ea_cur == ALL_ONES)
                        eb_next = eb_cur + ONE;
                end
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        len_next   = len_reg;
        count_next = count_reg;
        ia_next    = ia_reg;
        ib_next    = ib_reg;
        valid_next = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    mode_next  = bus.i_mode;
                    len_next   = bus.i_len;
                    count_next = '0;
                    if (bus.i_len == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                        valid_next = 1'b1;
                        count_next = LEN_W'(1);
                        ia_next    = vec_a;
                        ib_next    = vec_b;
                    end
                end
            end
            RUN: begin
                if (!bus.i_hold) begin
                    if (count_reg == len_reg) begin
                        state_next = DONE;
                    end else begin
                        valid_next = 1'b1;
                        count_next = (count_reg == CNT_MAX) ? count_reg : count_reg + LEN_W'(1);
                        ia_next    = vec_a;
                        ib_next    = vec_b;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            mode_reg  <= '0;
            len_reg   <= '0;
            count_reg <= '0;
            ia_reg    <= '0;
            ib_reg    <= '0;
            valid_reg <= 1'b0;
            xa_reg    <= SEED_A_INIT;
            xb_reg    <= SEED_B_INIT;
            k_reg     <= '0;
            ci_reg    <= '0;
            ea_reg    <= '0;
            eb_reg    <= '0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            len_reg   <= len_next;
            count_reg <= count_next;
            ia_reg    <= ia_next;
            ib_reg    <= ib_next;
            valid_reg <= valid_next;
            xa_reg    <= xa_next;
            xb_reg    <= xb_next;
            k_reg     <= k_next;
            ci_reg    <= ci_next;
            ea_reg    <= ea_next;
            eb_reg    <= eb_next;
        end
    end

    assign bus.o_ia    = ia_reg;
    assign bus.o_ib    = ib_reg;
    assign bus.o_valid = valid_reg;
    assign bus.o_busy  = (state_reg == RUN);
    assign bus.o_done  = (state_reg == DONE);
    assign bus.o_count = count_reg;

`ifdef STIM_GEN_SIG_EN
    logic [WIDTH-1:0] sig_reg, sig_next, sig_base;

    // Rotate-xor checksum over every emitted vector, restarted by each accepted start.
    always_comb begin
        sig_base = accept ? '0 : sig_reg;
        sig_next = sig_base;
        if (gen)
            sig_next = {sig_base[WIDTH-2:0], sig_base[WIDTH-1]} ^ vec_a ^ vec_b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sig_reg <= '0;
        else
            sig_reg <= sig_next;
    end

    assign bus.o_sig = sig_reg;
`else
    assign bus.o_sig = '0;
`endif
endmodule

// File: tb/tb_stim_gen.sv
// Scoreboard bench for stim_gen: a 32-bit and an 8-bit instance share the same
// run-control inputs; each has its own expected-vector queue and monitor.
module tb_stim_gen;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode_v = 2'd0;
    logic [15:0] len_v = 16'd0;
    logic        hold = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int vc32 = 0;
    int vc8  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] cnt;
        logic [31:0] sig;
    } vec_t;

    vec_t q32[$];
    vec_t q8[$];

    logic [31:0] xa_m = 32'h0000_0001;
    logic [31:0] xb_m = 32'h0000_ACE1;
    logic [31:0] sig32_m = '0;
    logic [7:0]  sig8_m = '0;

    always #5 clk = ~clk;

    stim_gen_if #(.WIDTH(32), .LEN_W(16)) bus32 ();
    stim_gen_if #(.WIDTH(8),  .LEN_W(16)) bus8 ();

    assign bus32.i_start = start;
    assign bus32.i_mode  = mode_v;
    assign bus32.i_len   = len_v;
    assign bus32.i_hold  = hold;
    assign bus8.i_start  = start;
    assign bus8.i_mode   = mode_v;
    assign bus8.i_len    = len_v;
    assign bus8.i_hold   = hold;

    stim_gen #(.WIDTH(32), .LEN_W(16), .SEED_A(32'h0000_0001), .SEED_B(32'h0000_ACE1)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    stim_gen #(.WIDTH(8), .LEN_W(16), .SEED_A(32'h0000_0001), .SEED_B(32'h0000_ACE1)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] s;
        s = x ^ (x << 13);
        s = s ^ (s >> 17);
        s = s ^ (s << 5);
        return s;
    endfunction

    // Corner table as {a, b} for the given operand width (32 or 8).
    function automatic logic [63:0] corner_pair(input int i, input int w);
        logic [31:0] m;
        logic [31:0] msb;
        m   = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        msb = (w == 32) ? 32'h8000_0000 : 32'h0000_0080;
        case (i % 8)
            0: return {32'h0, 32'h0};
            1: return {32'h0, m};
            2: return {m, 32'h0};
            3: return {m, m};
            4: return {32'h1, m};
            5: return {m, 32'h1};
            6: return {msb, msb};
            default: return {msb - 32'h1, 32'h1};
        endcase
    endfunction

    task automatic push_vecs(input logic [1:0] mode, input int len);
        logic [31:0] a32, b32, a8, b8;
        vec_t e32, e8;
        sig32_m = '0;
        sig8_m  = '0;
        for (int n = 0; n < len; n++) begin
            case (mode)
                2'd0: begin
                    xa_m = xs(xa_m);
                    xb_m = xs(xb_m);
                    a32 = xa_m;
                    b32 = xb_m;
                    a8  = {24'h0, xa_m[7:0]};
                    b8  = {24'h0, xb_m[7:0]};
                end
                2'd1: begin
                    a32 = 32'h1 << (n % 32);
                    b32 = ~a32;
                    a8  = 32'h1 << (n % 8);
                    b8  = ~a8 & 32'hFF;
                end
                2'd2: begin
                    {a32, b32} = corner_pair(n, 32);
                    {a8, b8}   = corner_pair(n, 8);
                end
                default: begin
                    a32 = 32'(n);
                    b32 = 32'h0;
                    a8  = 32'(n) & 32'hFF;
                    b8  = (32'(n) >> 8) & 32'hFF;
                end
            endcase
            sig32_m = {sig32_m[30:0], sig32_m[31]} ^ a32 ^ b32;
            sig8_m  = {sig8_m[6:0], sig8_m[7]} ^ a8[7:0] ^ b8[7:0];
            e32.a = a32; e32.b = b32; e32.cnt = 16'(n + 1);
            e8.a  = a8;  e8.b  = b8;  e8.cnt  = 16'(n + 1);
`ifdef STIM_GEN_SIG_EN
            e32.sig = sig32_m;
            e8.sig  = {24'h0, sig8_m};
`else
            e32.sig = '0;
            e8.sig  = '0;
`endif
            q32.push_back(e32);
            q8.push_back(e8);
        end
    endtask

    task automatic start_run(input logic [1:0] mode, input int len);
        @(posedge clk);
        #1;
        mode_v = mode;
        len_v  = 16'(len);
        start  = 1'b1;
        vc32   = 0;
        vc8    = 0;
        push_vecs(mode, len);
        @(posedge clk);
        #1;
        start = 1'b0;
        $display("run mode=%0d len=%0d issued at %0t", mode, len, $time);
    endtask

    // used = negedges already consumed since the start edge; chk_lat enables the latency check.
    task automatic wait_done(input int len, input int used, input bit chk_lat);
        int cyc;
        bit got;
        cyc = used;
        got = 1'b0;
        while (!got && cyc < len + 60) begin
            @(negedge clk);
            cyc++;
            if (bus32.o_done && bus8.o_done)
                got = 1'b1;
        end
        check("done_reached", 128'(got), 128'(1));
        if (chk_lat)
            check("done_latency", 128'(cyc), 128'(len + 1));
        check("done_count", {bus32.o_count, bus8.o_count}, {16'(len), 16'(len)});
        check("done_flags_valid_busy", {bus32.o_valid, bus8.o_valid, bus32.o_busy, bus8.o_busy}, 4'b0000);
        check("valid_cycles32", 128'(vc32), 128'(len));
        check("valid_cycles8", 128'(vc8), 128'(len));
        check("queue_drained", 128'(q32.size() + q8.size()), 128'(0));
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {bus32.o_ia, bus32.o_ib, bus32.o_sig, bus32.o_count,
                     bus32.o_valid, bus32.o_busy, bus32.o_done,
                     bus8.o_ia, bus8.o_ib, bus8.o_sig, bus8.o_count,
                     bus8.o_valid, bus8.o_busy, bus8.o_done}, '0);
    endtask

    task automatic wait_count4(input string name, input logic [15:0] target);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus32.o_count == target && bus32.o_valid)
                got = 1'b1;
        end
        check(name, 128'(got), 128'(1));
    endtask

    initial begin
        logic [79:0] saved;
        vec_t e;

        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    if (bus32.o_valid) begin
                        vc32++;
                        if (q32.size() == 0) begin
                            check("valid32_without_expected", 128'(bus32.o_valid), 128'(0));
                        end else begin
                            e = q32.pop_front();
                            check("vec32", {bus32.o_ia, bus32.o_ib, bus32.o_count, bus32.o_sig},
                                  {e.a, e.b, e.cnt, e.sig});
                            $display("vec32 #%0d a=%h b=%h", e.cnt, bus32.o_ia, bus32.o_ib);
                        end
                    end
                    if (bus8.o_valid) begin
                        vc8++;
                        if (q8.size() == 0) begin
                            check("valid8_without_expected", 128'(bus8.o_valid), 128'(0));
                        end else begin
                            e = q8.pop_front();
                            check("vec8", {24'h0, bus8.o_ia, 24'h0, bus8.o_ib, bus8.o_count, 24'h0, bus8.o_sig},
                                  {e.a, e.b, e.cnt, e.sig});
                            $display("vec8 #%0d a=%h b=%h", e.cnt, bus8.o_ia, bus8.o_ib);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random: first vector is seed 1 stepped once.
        start_run(2'd0, 3);
        @(negedge clk);
        check("first_rand", {bus32.o_ia, bus8.o_ia}, {32'h0004_2021, 8'h21});
        wait_done(3, 1, 1'b1);

        start_run(2'd1, 34);
        wait_done(34, 0, 1'b1);

        start_run(2'd2, 9);
        wait_done(9, 0, 1'b1);

        start_run(2'd3, 258);
        wait_done(258, 0, 1'b1);

        // Hold for three cycles after the second vector.
        start_run(2'd0, 5);
        wait_count4("hold_reach_count2", 16'd2);
        hold  = 1'b1;
        saved = {bus32.o_ia, bus32.o_ib, bus32.o_count};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid_low", {bus32.o_valid, bus8.o_valid}, 2'b00);
            check("hold_frozen", {bus32.o_ia, bus32.o_ib, bus32.o_count}, saved);
        end
        hold = 1'b0;
        wait_done(5, 0, 1'b0);

        // Zero-length run: done on the cycle after start, no valid ever.
        start_run(2'd0, 0);
        wait_done(0, 0, 1'b1);
        repeat (3) @(negedge clk);
        check("len0_no_valid", 128'(vc32 + vc8), 128'(0));

        // Reset mid-run at count 4 of 10.
        start_run(2'd0, 10);
        wait_count4("abort_reach_count4", 16'd4);
        reset = 1'b1;
        #1;
        check_reset_outputs("abort_reset_state");
        q32.delete();
        q8.delete();
        xa_m = 32'h0000_0001;
        xb_m = 32'h0000_ACE1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        start_run(2'd0, 3);
        @(negedge clk);
        check("first_rand_after_reset", {bus32.o_ia, bus8.o_ia}, {32'h0004_2021, 8'h21});
        wait_done(3, 1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
